f_register_file_nport: RTL and testbench

//  Parametrised FP register file for the FPU: 32 x FLEN registers, NREAD read ports (3 for fused mul-add rs3), one write port.

---
 rtl/f_register_file_nport.sv | 126 ++++++++++++
 tb/tb_f_register_file_nport.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_register_file_nport.sv
// FP register file: 32 x FLEN regs, NREAD bypassed read ports, one write port.
// Also holds frm, sticky fflags and the mstatus.FS state.
module f_register_file_nport #(
  parameter int FLEN  = 32,
  parameter int NREAD = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [5*NREAD-1:0]    f_rs_addr,
  output logic [FLEN*NREAD-1:0] f_rs_data,
  input  logic                  f_wen,
  input  logic [4:0]            f_rd,
  input  logic [FLEN-1:0]       f_w_data,
  input  logic                  f_w_single,
  input  logic [4:0]            f_flags_acc,
  input  logic                  f_flags_valid,
  input  logic                  csr_wen,
  input  logic [1:0]            csr_sel,
  input  logic [7:0]            csr_wdata,
  output logic [2:0]            f_frm_out,
  output logic [4:0]            f_flags,
  output logic [1:0]            fs_state,
  input  logic                  fs_clean,
  input  logic                  fs_off
);

  typedef enum logic [1:0] {
    FS_OFF   = 2'd0,
    FS_INIT  = 2'd1,
    FS_CLEAN = 2'd2,
    FS_DIRTY = 2'd3
  } fs_e;

  logic [FLEN-1:0] rf_q [32];
  logic [FLEN-1:0] rf_d [32];
  logic [FLEN-1:0] w_val;
  logic [2:0]      frm_q, frm_d;
  logic [4:0]      flags_q, flags_d;
  fs_e             fs_q, fs_d;
  logic            csr_ff;
  logic            csr_rm;
  logic [2:0]      rm_val;
  logic            change;

  // Write value; single results are NaN-boxed on a 64-bit file
  always_comb begin
    w_val = f_w_data;
    if (f_w_single && FLEN == 64) begin
      for (int b = 32; b < FLEN; b++) begin
        w_val[b] = 1'b1;
      end
    end
  end

  // Next register array contents
  always_comb begin
    rf_d = rf_q;
    if (f_wen) begin
      rf_d[f_rd] = w_val;
    end
  end

  // Read ports with write-through bypass
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [4:0] ra;
    assign ra = f_rs_addr[5*i +: 5];
    assign f_rs_data[FLEN*i +: FLEN] =
      (f_wen && f_rd == ra) ? w_val : rf_q[ra];
  end

  // fcsr fields and FS next state; CSR write beats flag accrual
  always_comb begin
    csr_ff = csr_wen &&
             (csr_sel == 2'd0 || csr_sel == 2'd2);
    csr_rm = csr_wen &&
             (csr_sel == 2'd1 || csr_sel == 2'd2);
    rm_val = (csr_sel == 2'd2) ? csr_wdata[7:5]
                               : csr_wdata[2:0];
    change = f_wen ||
             (f_flags_valid && (|f_flags_acc)) ||
             (csr_wen && csr_sel != 2'd3);

    flags_d = flags_q;
    if (csr_ff) begin
      flags_d = csr_wdata[4:0];
    end else if (f_flags_valid) begin
      flags_d = flags_q | f_flags_acc;
    end

    frm_d = frm_q;
    if (csr_rm && rm_val <= 3'd4) begin
      frm_d = rm_val;
    end

    fs_d = fs_q;
    if (fs_off) begin
      fs_d = FS_OFF;
    end else if (fs_clean) begin
      fs_d = FS_CLEAN;
    end else if (change) begin
      fs_d = FS_DIRTY;
    end
  end

  // State registers; reset discards any same-edge write
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int r = 0; r < 32; r++) begin
        rf_q[r] <= '0;
      end
      frm_q   <= 3'd0;
      flags_q <= 5'd0;
      fs_q    <= FS_INIT;
    end else begin
      rf_q    <= rf_d;
      frm_q   <= frm_d;
      flags_q <= flags_d;
      fs_q    <= fs_d;
    end
  end

  assign f_frm_out = frm_q;
  assign f_flags   = flags_q;
  assign fs_state  = fs_q;

endmodule

// File: tb/tb_f_register_file_nport.sv
// Directed bench for f_register_file_nport, FLEN=32 and FLEN=64.
// Expected values queued at drive time, popped at sample time.
module tb_f_register_file_nport;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [14:0]  rs_addr;
  logic         f_wen;
  logic [4:0]   f_rd;
  logic [63:0]  w_data;
  logic         w_single;
  logic [4:0]   acc;
  logic         acc_v;
  logic         csr_wen;
  logic [1:0]   csr_sel;
  logic [7:0]   csr_wdata;
  logic         fs_clean;
  logic         fs_off;

  logic [95:0]  d32;
  logic [191:0] d64;
  logic [2:0]   frm32, frm64;
  logic [4:0]   flags32, flags64;
  logic [1:0]   fs32, fs64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  f_register_file_nport #(.FLEN(32), .NREAD(3)) u32 (
    .CLK(CLK), .nRST(nRST),
    .f_rs_addr(rs_addr), .f_rs_data(d32),
    .f_wen(f_wen), .f_rd(f_rd),
    .f_w_data(w_data[31:0]), .f_w_single(w_single),
    .f_flags_acc(acc), .f_flags_valid(acc_v),
    .csr_wen(csr_wen), .csr_sel(csr_sel),
    .csr_wdata(csr_wdata),
    .f_frm_out(frm32), .f_flags(flags32),
    .fs_state(fs32),
    .fs_clean(fs_clean), .fs_off(fs_off)
  );

  f_register_file_nport #(.FLEN(64), .NREAD(3)) u64 (
    .CLK(CLK), .nRST(nRST),
    .f_rs_addr(rs_addr), .f_rs_data(d64),
    .f_wen(f_wen), .f_rd(f_rd),
    .f_w_data(w_data), .f_w_single(w_single),
    .f_flags_acc(acc), .f_flags_valid(acc_v),
    .csr_wen(csr_wen), .csr_sel(csr_sel),
    .csr_wdata(csr_wdata),
    .f_frm_out(frm64), .f_flags(flags64),
    .fs_state(fs64),
    .fs_clean(fs_clean), .fs_off(fs_off)
  );

  task automatic push(input string tag,
                      input logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop(input logic [63:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %h required none", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed %h required %h",
               x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    f_wen    = 1'b0;
    w_single = 1'b0;
    acc      = 5'd0;
    acc_v    = 1'b0;
    csr_wen  = 1'b0;
    fs_clean = 1'b0;
    fs_off   = 1'b0;
  endtask

  task automatic csr(input logic [1:0] s,
                     input logic [7:0] d);
    csr_wen   = 1'b1;
    csr_sel   = s;
    csr_wdata = d;
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    nRST      = 1'b0;
    f_rd      = 5'd0;
    w_data    = 64'd0;
    csr_sel   = 2'd0;
    csr_wdata = 8'd0;
    rs_addr   = {5'd31, 5'd5, 5'd0};

    // reset
    push("rst_d32_p0", 64'd0);
    push("rst_d32_p1", 64'd0);
    push("rst_d32_p2", 64'd0);
    push("rst_d64_p2", 64'd0);
    push("rst_frm",    64'd0);
    push("rst_flags",  64'd0);
    push("rst_fs32",   64'd1);
    push("rst_fs64",   64'd1);
    tick();
    nRST = 1'b1;
    pop(64'(d32[31:0]));
    pop(64'(d32[63:32]));
    pop(64'(d32[95:64]));
    pop(d64[191:128]);
    pop(64'(frm32));
    pop(64'(flags32));
    pop(64'(fs32));
    pop(64'(fs64));

    // write f5, read next cycle on all ports
    f_wen  = 1'b1;
    f_rd   = 5'd5;
    w_data = 64'h3F80_0000;
    tick();
    idle();
    rs_addr = {5'd5, 5'd5, 5'd5};
    push("f5_p0", 64'h3F80_0000);
    push("f5_p1", 64'h3F80_0000);
    push("f5_p2", 64'h3F80_0000);
    push("f5_d64", 64'h0000_0000_3F80_0000);
    push("fs_dirty_wr", 64'd3);
    #1;
    pop(64'(d32[31:0]));
    pop(64'(d32[63:32]));
    pop(64'(d32[95:64]));
    pop(d64[63:0]);
    pop(64'(fs32));

    // same-cycle bypass
    f_wen  = 1'b1;
    w_data = 64'h4000_0000;
    push("byp_p1", 64'h4000_0000);
    push("byp_d64_p2", 64'h0000_0000_4000_0000);
    #1;
    pop(64'(d32[63:32]));
    pop(d64[191:128]);
    tick();
    idle();
    push("f5_stored", 64'h4000_0000);
    #1;
    pop(64'(d32[31:0]));

    // f0 is an ordinary register
    f_wen  = 1'b1;
    f_rd   = 5'd0;
    w_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    idle();
    rs_addr = {5'd0, 5'd5, 5'd0};
    push("f0_d32", 64'h9ABC_DEF0);
    push("f0_d64", 64'h1234_5678_9ABC_DEF0);
    push("f5_kept", 64'h4000_0000);
    #1;
    pop(64'(d32[95:64]));
    pop(d64[63:0]);
    pop(64'(d32[63:32]));

    // NaN-boxing of single writes
    rs_addr  = {5'd2, 5'd2, 5'd2};
    f_wen    = 1'b1;
    f_rd     = 5'd2;
    w_single = 1'b1;
    w_data   = 64'h0000_0000_4049_0FDB;
    push("box_byp", 64'hFFFF_FFFF_4049_0FDB);
    #1;
    pop(d64[127:64]);
    tick();
    idle();
    push("box_d64", 64'hFFFF_FFFF_4049_0FDB);
    push("box_d32", 64'h4049_0FDB);
    #1;
    pop(d64[63:0]);
    pop(64'(d32[31:0]));
    f_wen = 1'b1;
    tick();
    idle();
    push("nobox_d64", 64'h0000_0000_4049_0FDB);
    #1;
    pop(d64[191:128]);

    // sticky flag accrual
    acc_v = 1'b1;
    acc   = 5'b00001;
    tick();
    acc = 5'b10000;
    push("acc_flags32", 64'b10001);
    push("acc_flags64", 64'b10001);
    tick();
    idle();
    pop(64'(flags32));
    pop(64'(flags64));

    // CSR write beats accrual
    acc_v = 1'b1;
    acc   = 5'b00100;
    push("csr_wins", 64'd0);
    csr(2'd0, 8'h00);
    pop(64'(flags32));

    // frm / fcsr writes
    push("frm_sel1", 64'd2);
    csr(2'd1, 8'h02);
    pop(64'(frm32));
    push("fcsr_rsv_frm", 64'd2);
    push("fcsr_rsv_flags", 64'b00011);
    csr(2'd2, 8'hA3);
    pop(64'(frm32));
    pop(64'(flags32));
    push("fcsr_frm", 64'd4);
    push("fcsr_flags", 64'b00001);
    csr(2'd2, 8'h81);
    pop(64'(frm64));
    pop(64'(flags64));
    push("sel3_frm", 64'd4);
    push("sel3_flags", 64'b00001);
    csr(2'd3, 8'hFF);
    pop(64'(frm32));
    pop(64'(flags32));
    push("frm_3", 64'd3);
    csr(2'd1, 8'h03);
    pop(64'(frm32));
    push("frm_rsv7", 64'd3);
    csr(2'd1, 8'h07);
    pop(64'(frm32));

    // reset during a write
    nRST   = 1'b0;
    f_wen  = 1'b1;
    f_rd   = 5'd7;
    w_data = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    nRST = 1'b1;
    idle();
    rs_addr = {5'd7, 5'd5, 5'd7};
    push("rst_wr_d32", 64'd0);
    push("rst_wr_d64", 64'd0);
    push("rst_f5", 64'd0);
    push("rst2_frm", 64'd0);
    push("rst2_flags", 64'd0);
    push("rst2_fs", 64'd1);
    #1;
    pop(64'(d32[31:0]));
    pop(d64[191:128]);
    pop(64'(d32[63:32]));
    pop(64'(frm32));
    pop(64'(flags32));
    pop(64'(fs32));

    // FS state machine
    fs_clean = 1'b1;
    push("fs_clean", 64'd2);
    tick();
    idle();
    pop(64'(fs32));
    push("fs_sel3_hold", 64'd2);
    csr(2'd3, 8'h00);
    pop(64'(fs32));
    acc_v = 1'b1;
    acc   = 5'd0;
    push("fs_acc0_hold", 64'd2);
    tick();
    idle();
    pop(64'(fs32));
    f_wen  = 1'b1;
    f_rd   = 5'd9;
    w_data = 64'h11;
    push("fs_wr_dirty", 64'd3);
    tick();
    idle();
    pop(64'(fs32));
    f_wen    = 1'b1;
    fs_clean = 1'b1;
    push("fs_clean_wins", 64'd2);
    tick();
    idle();
    pop(64'(fs32));
    f_wen    = 1'b1;
    fs_clean = 1'b1;
    fs_off   = 1'b1;
    push("fs_off32", 64'd0);
    push("fs_off64", 64'd0);
    tick();
    idle();
    pop(64'(fs32));
    pop(64'(fs64));

    // FS=Off does not gate writes
    f_wen   = 1'b1;
    f_rd    = 5'd9;
    w_data  = 64'h55;
    rs_addr = {5'd9, 5'd9, 5'd9};
    push("off_wr_fs", 64'd3);
    push("off_wr_data", 64'h55);
    tick();
    idle();
    #1;
    pop(64'(fs32));
    pop(64'(d32[95:64]));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: observed %0d required 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
